// File: rtl/month_year_counter.sv
// -----------------------------------------------------------------------------
// month_year_counter
//
// Calendar month/year stage fed by the day counter's end-of-month carry.
// Advances month (1-12) and year (0-YEAR_MAX, meaning 2000+year), reports the
// length of the current month back to the day counter (leap-year aware), and
// drives BCD digits for the display. Month/year can be loaded from the
// setting UI; malformed loads are rejected with a one-cycle error pulse.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous, active-low reset
//   day_carry      end-of-month level from the day counter (edge detected)
//   set_valid      load request, sampled every cycle
//   set_month      month to load, 1-12
//   set_year       year to load, 0-YEAR_MAX
//   day_limit      days in current month: 28, 29, 30 or 31
//   month1/month2  month tens / ones digit, BCD
//   year1/year2    year tens / ones digit, BCD
//   century_carry  one-cycle pulse when year wraps YEAR_MAX -> 0
//   set_err        one-cycle pulse when a load request is rejected
// -----------------------------------------------------------------------------
module month_year_counter #(
    parameter int YEAR_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_carry,
    input  logic       set_valid,
    input  logic [3:0] set_month,
    input  logic [6:0] set_year,
    output logic [4:0] day_limit,
    output logic [3:0] month1,
    output logic [3:0] month2,
    output logic [3:0] year1,
    output logic [3:0] year2,
    output logic       century_carry,
    output logic       set_err
);

    localparam logic [6:0] YEAR_MAX_L = 7'(YEAR_MAX);

    logic [3:0] month;
    logic [6:0] year;
    logic       carry_d;
    logic       adv;
    logic       set_ok;

    // Tens digit of a value that legally never exceeds 99; clamped so an
    // unreachable out-of-range register can never drive a non-BCD digit.
    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return (t > 7'd9) ? 4'd9 : t[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        logic [6:0] o;
        o = v % 7'd10;
        return o[3:0];
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                 input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            // year%4==0 suffices inside 2000-2099 (2000 is a leap year)
            4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // A held carry yields a single advance; carry_d resets high so a carry
    // already asserted when reset releases is not mistaken for a new edge.
    assign adv    = day_carry & ~carry_d;
    assign set_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_year <= YEAR_MAX_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            month         <= 4'd1;
            year          <= 7'd0;
            carry_d       <= 1'b1;
            century_carry <= 1'b0;
            set_err       <= 1'b0;
        end else begin
            carry_d       <= day_carry;
            century_carry <= 1'b0;
            set_err       <= 1'b0;
            if (set_valid) begin
                // A coincident carry edge is dropped, not deferred.
                if (set_ok) begin
                    month <= set_month;
                    year  <= set_year;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (adv) begin
                if ((month >= 4'd1) && (month < 4'd12)) begin
                    month <= month + 4'd1;
                end else begin
                    // December, or any illegal month, rolls into January.
                    month <= 4'd1;
                    if (year >= YEAR_MAX_L) begin
                        year          <= 7'd0;
                        century_carry <= 1'b1;
                    end else begin
                        year <= year + 7'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        day_limit = days_in_month(month, year);
        month1    = bcd_tens({3'd0, month});
        month2    = bcd_ones({3'd0, month});
        year1     = bcd_tens(year);
        year2     = bcd_ones(year);
    end

endmodule

// File: tb/tb_month_year_counter.sv
// -----------------------------------------------------------------------------
// tb_month_year_counter
//
// Directed, table-driven bench for month_year_counter. Each table row is one
// clock of stimulus followed by the outputs expected after that edge.
// -----------------------------------------------------------------------------
module tb_month_year_counter;

    logic       clk;
    logic       rst;
    logic       day_carry;
    logic       set_valid;
    logic [3:0] set_month;
    logic [6:0] set_year;
    logic [4:0] day_limit;
    logic [3:0] month1, month2, year1, year2;
    logic       century_carry;
    logic       set_err;

    int n_cmp;
    int n_fail;

    month_year_counter #(.YEAR_MAX(99)) dut (
        .clk           (clk),
        .rst           (rst),
        .day_carry     (day_carry),
        .set_valid     (set_valid),
        .set_month     (set_month),
        .set_year      (set_year),
        .day_limit     (day_limit),
        .month1        (month1),
        .month2        (month2),
        .year1         (year1),
        .year2         (year2),
        .century_carry (century_carry),
        .set_err       (set_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [3:0] sm;
        logic [6:0] sy;
        logic       dc;
        logic [3:0] m1, m2, y1, y2;
        logic [4:0] lim;
        logic       err;
        logic       cc;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] m1,
                           input logic [3:0] m2, input logic [3:0] y1,
                           input logic [3:0] y2, input logic [4:0] lim,
                           input logic err, input logic cc);
        chk({tag, ".month1"}, 32'(month1), 32'(m1));
        chk({tag, ".month2"}, 32'(month2), 32'(m2));
        chk({tag, ".year1"}, 32'(year1), 32'(y1));
        chk({tag, ".year2"}, 32'(year2), 32'(y2));
        chk({tag, ".day_limit"}, 32'(day_limit), 32'(lim));
        chk({tag, ".set_err"}, 32'(set_err), 32'(err));
        chk({tag, ".century_carry"}, 32'(century_carry), 32'(cc));
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent calendar reference for the 24-month walk.
    function automatic logic [4:0] ref_days(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 5'd29 : 5'd28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 5'd30;
        return 5'd31;
    endfunction

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        day_carry = 1'b1;
        set_valid = 1'b0;
        set_month = 4'd0;
        set_year  = 7'd0;

        //          sv  sm  sy  dc  m1 m2 y1 y2 lim err cc
        vt[0]  = '{1'b1, 4'd2, 7'd1, 1'b0, 4'd0, 4'd2, 4'd0, 4'd1, 5'd28, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 4'd2, 7'd4, 1'b0, 4'd0, 4'd2, 4'd0, 4'd4, 5'd29, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 4'd4, 7'd4, 1'b0, 4'd0, 4'd4, 4'd0, 4'd4, 5'd30, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 4'd7, 7'd4, 1'b0, 4'd0, 4'd7, 4'd0, 4'd4, 5'd31, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 4'd13, 7'd4, 1'b0, 4'd0, 4'd7, 4'd0, 4'd4, 5'd31, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 4'd0, 7'd0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd4, 5'd31, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 4'd5, 7'd100, 1'b0, 4'd0, 4'd7, 4'd0, 4'd4, 5'd31, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 4'd0, 7'd5, 1'b0, 4'd0, 4'd7, 4'd0, 4'd4, 5'd31, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 4'd11, 7'd23, 1'b0, 4'd1, 4'd1, 4'd2, 4'd3, 5'd30, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 4'd0, 7'd0, 1'b1, 4'd1, 4'd2, 4'd2, 4'd3, 5'd31, 1'b0, 1'b0};
        vt[10] = '{1'b0, 4'd0, 7'd0, 1'b0, 4'd1, 4'd2, 4'd2, 4'd3, 5'd31, 1'b0, 1'b0};
        vt[11] = '{1'b0, 4'd0, 7'd0, 1'b1, 4'd0, 4'd1, 4'd2, 4'd4, 5'd31, 1'b0, 1'b0};
        vt[12] = '{1'b0, 4'd0, 7'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd4, 5'd31, 1'b0, 1'b0};
        vt[13] = '{1'b1, 4'd12, 7'd99, 1'b0, 4'd1, 4'd2, 4'd9, 4'd9, 5'd31, 1'b0, 1'b0};
        vt[14] = '{1'b0, 4'd0, 7'd0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b1};
        vt[15] = '{1'b0, 4'd0, 7'd0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0};
        vt[16] = '{1'b0, 4'd0, 7'd0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0};
        vt[17] = '{1'b1, 4'd6, 7'd10, 1'b1, 4'd0, 4'd6, 4'd1, 4'd0, 5'd30, 1'b0, 1'b0};
        vt[18] = '{1'b0, 4'd0, 7'd0, 1'b1, 4'd0, 4'd6, 4'd1, 4'd0, 5'd30, 1'b0, 1'b0};
        vt[19] = '{1'b0, 4'd0, 7'd0, 1'b0, 4'd0, 4'd6, 4'd1, 4'd0, 5'd30, 1'b0, 1'b0};
        vt[20] = '{1'b1, 4'd2, 7'd3, 1'b0, 4'd0, 4'd2, 4'd0, 4'd3, 5'd28, 1'b0, 1'b0};

        // Reset held with day_carry high
        #12;
        chk_all("in_reset", 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("held_carry%0d.month2", i), 32'(month2), 32'd1);
        end
        chk_all("held_carry", 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0);

        // Drop and re-raise: first real edge, year 0 is leap
        day_carry = 1'b0;
        step();
        chk("drop.month2", 32'(month2), 32'd1);
        day_carry = 1'b1;
        step();
        chk_all("reraise", 4'd0, 4'd2, 4'd0, 4'd0, 5'd29, 1'b0, 1'b0);
        day_carry = 1'b0;
        step();

        // Table vectors
        for (int i = 0; i < 21; i++) begin
            set_valid = vt[i].sv;
            set_month = vt[i].sm;
            set_year  = vt[i].sy;
            day_carry = vt[i].dc;
            step();
            chk_all($sformatf("vec%0d", i), vt[i].m1, vt[i].m2, vt[i].y1,
                    vt[i].y2, vt[i].lim, vt[i].err, vt[i].cc);
        end

        // 24 single-cycle pulses from January 2000
        set_valid = 1'b1;
        set_month = 4'd1;
        set_year  = 7'd0;
        day_carry = 1'b0;
        step();
        set_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            int em, ey;
            em = (k % 12) + 1;
            ey = k / 12;
            day_carry = 1'b1;
            step();
            chk_all($sformatf("walk%0d", k), 4'(em / 10), 4'(em % 10),
                    4'(ey / 10), 4'(ey % 10), ref_days(em, ey), 1'b0, 1'b0);
            day_carry = 1'b0;
            step();
        end

        // Reset mid-sequence takes effect without a clock edge
        set_valid = 1'b1;
        set_month = 4'd5;
        set_year  = 7'd7;
        step();
        set_valid = 1'b0;
        day_carry = 1'b1;
        step();
        chk_all("pre_reset", 4'd0, 4'd6, 4'd0, 4'd7, 5'd30, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_reset", 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0);
        day_carry = 1'b0;
        #3;
        rst = 1'b1;
        step();
        step();
        chk_all("post_reset", 4'd0, 4'd1, 4'd0, 4'd0, 5'd31, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/month_year_counter.md
# month_year_counter

Calendar month/year stage that sits downstream of the day counter. It receives the day counter's end-of-month carry, advances month and year (2000–2099, years encoded 0–99), and returns the days-in-month limit (28/29/30/31, leap-year aware) that the day counter compares against. It supports a synchronous load of month/year from the setting UI and drives BCD digits for the seven-segment display path. It runs entirely on the system clock; the carry is treated as a synchronous, edge-detected event, not as a clock.

## Interface
Parameters:
- `YEAR_MAX`, 99, last encoded year before wrap to 0; year N means 2000+N.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `day_carry`  input  1  end-of-month indication from day counter; may be high for one or more cycles
- `set_valid`  input  1  load request, sampled each cycle
- `set_month`  input  4  month to load, 1–12 binary
- `set_year`  input  7  year to load, 0–`YEAR_MAX` binary
- `day_limit`  output  5  days in current month (28, 29, 30, 31)
- `month1`  output  4  month tens digit, BCD
- `month2`  output  4  month ones digit, BCD
- `year1`  output  4  year tens digit, BCD
- `year2`  output  4  year ones digit, BCD
- `century_carry`  output  1  one-cycle pulse on year wrap `YEAR_MAX`→0
- `set_err`  output  1  one-cycle pulse when a load request is rejected

## Operation
- State registers: `month` (4 b, 1–12), `year` (7 b, 0–`YEAR_MAX`), `carry_d` (1 b), `century_carry`, `set_err`.
- Edge detect: `adv = day_carry & ~carry_d`; `carry_d <= day_carry` every cycle. A `day_carry` held high for any number of cycles produces exactly one advance.
- Priority per cycle: reset > load > advance > hold.
- Load (`set_valid`=1): if 1 ≤ `set_month` ≤ 12 and `set_year` ≤ `YEAR_MAX`, load both; else keep state and pulse `set_err`. A coincident `adv` is discarded in either case, not deferred.
- Advance (`adv`=1, no load): month < 12 → month+1; month = 12 → month=1 and year+1; year = `YEAR_MAX` at that wrap → year=0 and pulse `century_carry`.
- `day_limit` is combinational from registered `month`/`year`: months 4, 6, 9, 11 → 30; month 2 → 29 if year%4 = 0 (year[1:0]=0, 2000 is leap), else 28; all others → 31.
- BCD: month1 = month/10, month2 = month%10; year1 = year/10, year2 = year%10; combinational, never exceed 9.
- Illegal register values are unreachable; defensively, any month outside 1–12 is treated as 12 on advance (goes to 1) and decodes to 31.

## Timing
- Reset values: month=1, year=0, carry_d=1, century_carry=0, set_err=0; hence day_limit=31, month1=0, month2=1, year1=0, year2=0. carry_d=1 prevents a `day_carry` held high through reset release from causing an advance.
- Advance latency: `day_carry` rises before edge N → new month/year visible after edge N; day_limit updates in the same cycle as month.
- Load latency: `set_valid` sampled at edge N → values visible after edge N; `set_err` high for the cycle after edge N only.
- `century_carry` high for exactly the one cycle following the wrapping edge.
- Reset asserted mid-operation forces reset values immediately, independent of clk; no pending edge or load survives.
- Another `adv` requires `day_carry` to drop low for at least one sampled cycle.

## Test plan
- Reset with `day_carry`=1 held, release, keep high 5 cycles → month=1, year=0, day_limit=31, no advance; drop and re-raise → month=2, day_limit=28 is wrong for year 0: expect 29.
- Load month=2/year=1 → day_limit=28; load year=4 → 29; load month=4 → 30; month=7 → 31.
- Load month=12/year=99, one `day_carry` pulse → month=1, year=0, digits 0,1,0,0, `century_carry` high exactly 1 cycle.
- Load month=13 (and separately year=100) → state unchanged, `set_err` 1 cycle; month=0 → same.
- `set_valid` (month=6, year=10) in the same cycle as a `day_carry` rising edge → month=6, year=10, no later advance.
- Advance 24 single-cycle pulses from month=1/year=0 → month=1/year=2, day_limit tracking each month; assert reset mid-sequence → outputs return to reset values asynchronously.
